// File: rtl/lt_sequencer_pkg.sv
// ============================================================================
// Module   : lt_sequencer_pkg
// Purpose  : Shared box-position encodings, state encodings and widths for
//            the latency-test sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package lt_sequencer_pkg;

    localparam logic [1:0] LT_POS_NONE        = 2'd0;
    localparam logic [1:0] LT_POS_TOPLEFT     = 2'd1;
    localparam logic [1:0] LT_POS_CENTER      = 2'd2;
    localparam logic [1:0] LT_POS_BOTTOMRIGHT = 2'd3;

    localparam int LT_DEB_W = 8;
    localparam int LT_CNT_W = 24;

    localparam logic [LT_CNT_W-1:0] LT_RESULT_INVALID = 24'hFFFFFF;

    typedef enum logic [2:0] {
        LT_IDLE   = 3'd0,
        LT_DARK   = 3'd1,
        LT_ARM    = 3'd2,
        LT_MEAS   = 3'd3,
        LT_SETTLE = 3'd4
    } lt_state_e;

endpackage

`default_nettype wire

// File: rtl/lt_sequencer_debounce.sv
// ============================================================================
// Module   : lt_sensor_debounce
// Purpose  : Two-flop synchronizer for the photodiode comparator followed by
//            a saturating consecutive-high sample counter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lt_sensor_debounce
    import lt_sequencer_pkg::*;
(
    input  logic                clk27,
    input  logic                reset,
    input  logic                sensor_in,
    output logic                sync2,
    output logic [LT_DEB_W-1:0] deb_cnt
);

    localparam logic [LT_DEB_W-1:0] DEB_ONE = LT_DEB_W'(1);

    logic sync1;

    always_ff @(posedge clk27) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync1 <= sensor_in;
            sync2 <= sync1;
            if (!sync2) begin
                deb_cnt <= '0;
            end else if (deb_cnt != '1) begin
                deb_cnt <= deb_cnt + DEB_ONE;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/lt_sequencer.sv
// ============================================================================
// Module   : lt_sequencer
// Purpose  : Display-latency measurement sequencer: blanks, waits for dark,
//            flashes a white box on a vsync edge and times the sensor rise.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lt_sequencer
    import lt_sequencer_pkg::*;
#(
    parameter int unsigned           DEBOUNCE_LEN    = 4,
    parameter logic [LT_CNT_W-1:0]   TIMEOUT_CYC     = 24'd2_700_000,
    parameter int unsigned           DARK_FRAMES_MAX = 8,
    parameter int unsigned           SETTLE_FRAMES   = 2
) (
    input  logic                clk27,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [1:0]          pos_sel,
    input  logic                vsync_in,
    input  logic                sensor_in,
    output logic                lt_active,
    output logic [1:0]          lt_mode,
    output logic                busy,
    output logic                done,
    output logic [LT_CNT_W-1:0] result,
    output logic                timeout,
    output logic                err_lit
);

    localparam logic [LT_DEB_W-1:0] DEB_TGT      = LT_DEB_W'(DEBOUNCE_LEN);
    localparam logic [7:0]          DARK_TGT     = 8'(DARK_FRAMES_MAX);
    localparam logic [7:0]          SETTLE_TGT   = 8'(SETTLE_FRAMES);
    // Removes synchronizer plus debounce delay so result is raw-edge referenced
    localparam logic [LT_CNT_W-1:0] DEB_ADJ      = LT_CNT_W'(DEBOUNCE_LEN + 1);
    localparam logic [LT_CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CYC - 24'd1;

    logic                sync2;
    logic [LT_DEB_W-1:0] deb_cnt;
    logic                vs_prev;
    logic                vs_fall;

    lt_state_e           state, state_nxt;
    logic [1:0]          pos_lat, pos_nxt;
    logic [7:0]          dark_cnt, dark_nxt;
    logic [7:0]          settle_cnt, settle_nxt;
    logic [LT_CNT_W-1:0] lat_cnt, lat_nxt;
    logic [1:0]          mode_nxt;
    logic                done_nxt;
    logic [LT_CNT_W-1:0] result_nxt;
    logic                timeout_nxt;
    logic                err_nxt;

    lt_sensor_debounce u_debounce (
        .clk27     (clk27),
        .reset     (reset),
        .sensor_in (sensor_in),
        .sync2     (sync2),
        .deb_cnt   (deb_cnt)
    );

    assign vs_fall = !vsync_in && vs_prev;

    always_comb begin
        state_nxt   = state;
        pos_nxt     = pos_lat;
        dark_nxt    = dark_cnt;
        settle_nxt  = settle_cnt;
        lat_nxt     = lat_cnt;
        mode_nxt    = lt_mode;
        done_nxt    = 1'b0;
        result_nxt  = result;
        timeout_nxt = timeout;
        err_nxt     = err_lit;

        case (state)
            LT_IDLE: begin
                mode_nxt = LT_POS_NONE;
                if (start) begin
                    pos_nxt   = pos_sel;
                    dark_nxt  = 8'd0;
                    state_nxt = LT_DARK;
                end
            end
            LT_DARK: begin
                mode_nxt = LT_POS_NONE;
                if (vs_fall) begin
                    if (!sync2) begin
                        state_nxt = LT_ARM;
                    end else if (dark_cnt + 8'd1 == DARK_TGT) begin
                        err_nxt     = 1'b1;
                        timeout_nxt = 1'b0;
                        result_nxt  = LT_RESULT_INVALID;
                        done_nxt    = 1'b1;
                        settle_nxt  = 8'd0;
                        state_nxt   = LT_SETTLE;
                    end else begin
                        dark_nxt = dark_cnt + 8'd1;
                    end
                end
            end
            LT_ARM: begin
                if (vs_fall) begin
                    mode_nxt  = pos_lat;
                    lat_nxt   = '0;
                    state_nxt = LT_MEAS;
                end
            end
            LT_MEAS: begin
                lat_nxt = lat_cnt + 24'd1;
                if (deb_cnt == DEB_TGT) begin
                    result_nxt  = lat_cnt - DEB_ADJ;
                    timeout_nxt = 1'b0;
                    err_nxt     = 1'b0;
                    done_nxt    = 1'b1;
                    mode_nxt    = LT_POS_NONE;
                    settle_nxt  = 8'd0;
                    state_nxt   = LT_SETTLE;
                end else if (lat_cnt == TIMEOUT_LAST) begin
                    result_nxt  = LT_RESULT_INVALID;
                    timeout_nxt = 1'b1;
                    err_nxt     = 1'b0;
                    done_nxt    = 1'b1;
                    mode_nxt    = LT_POS_NONE;
                    settle_nxt  = 8'd0;
                    state_nxt   = LT_SETTLE;
                end
            end
            LT_SETTLE: begin
                mode_nxt = LT_POS_NONE;
                if (vs_fall) begin
                    if (settle_cnt + 8'd1 >= SETTLE_TGT) begin
                        state_nxt = LT_IDLE;
                    end else begin
                        settle_nxt = settle_cnt + 8'd1;
                    end
                end
            end
            default: begin
                mode_nxt  = LT_POS_NONE;
                state_nxt = LT_IDLE;
            end
        endcase

        // Abort discards the run without touching the reported outcome
        if (abort) begin
            state_nxt   = LT_IDLE;
            mode_nxt    = LT_POS_NONE;
            done_nxt    = 1'b0;
            result_nxt  = result;
            timeout_nxt = timeout;
            err_nxt     = err_lit;
        end
    end

    always_ff @(posedge clk27) begin
        if (reset) begin
            state      <= LT_IDLE;
            vs_prev    <= 1'b0;
            pos_lat    <= LT_POS_NONE;
            dark_cnt   <= 8'd0;
            settle_cnt <= 8'd0;
            lat_cnt    <= '0;
            lt_active  <= 1'b0;
            busy       <= 1'b0;
            lt_mode    <= LT_POS_NONE;
            done       <= 1'b0;
            result     <= '0;
            timeout    <= 1'b0;
            err_lit    <= 1'b0;
        end else begin
            state      <= state_nxt;
            vs_prev    <= vsync_in;
            pos_lat    <= pos_nxt;
            dark_cnt   <= dark_nxt;
            settle_cnt <= settle_nxt;
            lat_cnt    <= lat_nxt;
            lt_active  <= (state_nxt != LT_IDLE);
            busy       <= (state_nxt != LT_IDLE);
            lt_mode    <= mode_nxt;
            done       <= done_nxt;
            result     <= result_nxt;
            timeout    <= timeout_nxt;
            err_lit    <= err_nxt;
        end
    end

endmodule

`default_nettype wire
